// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling: 2-flop line synchronizer, mid-bit sampling,
// registered frame-done pulse, data word and stop-bit framing error.
module uart_rx_oversampled #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    // Tick counter must reach SB_TICK-1, which exceeds 4 bits for 1.5/2 stop bits
    localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic            r_rx_meta;
    logic            r_rx_s;

    state_t          w_state_next;
    logic [SW-1:0]   w_s_next;
    logic [NW-1:0]   w_n_next;
    logic [DBIT-1:0] w_b_next;
    logic [DBIT-1:0] w_dout_next;
    logic            w_ferr_next;
    logic            w_done_next;

    // Line synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_s          <= w_s_next;
            r_n          <= w_n_next;
            r_b          <= w_b_next;
            dout         <= w_dout_next;
            frame_err    <= w_ferr_next;
            rx_done_tick <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_dout_next  = dout;
        w_ferr_next  = frame_err;
        w_done_next  = 1'b0;

        case (r_state)
            IDLE: begin
                // Start edge is taken without waiting for a tick
                if (!r_rx_s) begin
                    w_state_next = START;
                    w_s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == SW'(7)) begin
                        if (!r_rx_s) begin
                            w_state_next = DATA;
                            w_s_next     = '0;
                            w_n_next     = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_next = '0;
                        w_b_next = DBIT'({r_rx_s, r_b} >> 1);
                        if (r_n == NW'(DBIT - 1)) begin
                            w_state_next = STOP;
                        end else begin
                            w_n_next = r_n + NW'(1);
                        end
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_state_next = IDLE;
                        w_dout_next  = r_b;
                        w_ferr_next  = ~r_rx_s;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: s_tick every 4 clk, 64 clk per bit.
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick = 1'b0;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    int         cyc      = 0;
    int         done_cyc[$];
    logic [7:0] done_dout[$];
    logic       tick_en  = 1'b0;
    logic [1:0] tick_cnt = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Tick generator and done-pulse monitor, both on the inactive edge
    always @(negedge clk) begin
        cyc++;
        if (tick_en) begin
            tick_cnt = tick_cnt + 2'd1;
            s_tick   = (tick_cnt == 2'd3);
        end else begin
            s_tick = 1'b0;
        end
        if (rx_done_tick === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            done_dout.push_back(dout);
        end
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
        drive_bit(stop, 64);
    endtask

    int         base;
    int         k;
    logic [7:0] d;
    logic [1:0] snap_st;
    logic [3:0] snap_s;
    logic [2:0] snap_n;
    logic [7:0] snap_b;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'd0);
        reset   = 1'b0;
        tick_en = 1'b1;
        repeat (10) @(negedge clk);

        // Clean frame
        base = done_cnt;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 64);
        check("a5_count", 32'(done_cnt), 32'(base + 1));
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_ferr", 32'(frame_err), 32'd0);

        // Short low glitch is rejected at the start-bit midpoint
        base = done_cnt;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 200);
        check("glitch_count", 32'(done_cnt), 32'(base));
        check("glitch_state", 32'(dut.r_state), 32'd0);
        check("glitch_dout", 32'(dout), 32'hA5);
        base = done_cnt;
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 64);
        check("3c_count", 32'(done_cnt), 32'(base + 1));
        check("3c_dout", 32'(dout), 32'h3C);

        // Low stop bit: framing error, then held-low line restarts in START
        base = done_cnt;
        d = 8'hFF;
        drive_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
        rx = 1'b0;
        k  = 0;
        while (rx_done_tick !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("ff_done_seen", 32'(rx_done_tick), 32'd1);
        @(negedge clk);
        check("ff_break_start", 32'(dut.r_state), 32'd1);
        drive_bit(1'b1, 200);
        check("ff_count", 32'(done_cnt), 32'(base + 1));
        check("ff_dout", 32'(dout), 32'hFF);
        check("ff_ferr", 32'(frame_err), 32'd1);

        // Reset in the middle of data bit 4 of 0x5A
        base = done_cnt;
        d = 8'h5A;
        drive_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 64);
        drive_bit(d[4], 32);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rstmid_dout", 32'(dout), 32'h00);
        check("rstmid_ferr", 32'(frame_err), 32'd0);
        drive_bit(1'b1, 200);
        check("rstmid_count", 32'(done_cnt), 32'(base));
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 64);
        check("81_count", 32'(done_cnt), 32'(base + 1));
        check("81_dout", 32'(dout), 32'h81);

        // Back-to-back frames with no idle gap
        base = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, 64);
        check("b2b_count", 32'(done_cnt), 32'(base + 2));
        if (done_cyc.size() >= base + 2) begin
            check("b2b_dout0", 32'(done_dout[base]), 32'h00);
            check("b2b_dout1", 32'(done_dout[base + 1]), 32'hFF);
            check("b2b_gap_ge_640", 32'(done_cyc[base + 1] - done_cyc[base] >= 640), 32'd1);
        end

        // Ticks stop for 100 clk mid-DATA with the line frozen
        base = done_cnt;
        d = 8'h96;
        drive_bit(1'b0, 64);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 64);
        drive_bit(d[3], 20);
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        snap_st = dut.r_state;
        snap_s  = dut.r_s;
        snap_n  = dut.r_n;
        snap_b  = dut.r_b;
        check("pause_in_data", 32'(snap_st), 32'd2);
        check("pause_bit3", 32'(snap_n), 32'd3);
        repeat (100) @(negedge clk);
        check("pause_state", 32'(dut.r_state), 32'(snap_st));
        check("pause_s", 32'(dut.r_s), 32'(snap_s));
        check("pause_n", 32'(dut.r_n), 32'(snap_n));
        check("pause_b", 32'(dut.r_b), 32'(snap_b));
        tick_en = 1'b1;
        drive_bit(d[3], 42);
        for (int i = 4; i < 8; i++) drive_bit(d[i], 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b1, 64);
        check("96_count", 32'(done_cnt), 32'(base + 1));
        check("96_dout", 32'(dout), 32'h96);
        check("96_ferr", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
